// File: rtl/pred_pht.sv
// pred_pht: pattern history table of 2-bit saturating counters for the IFU
// branch predictor. A sweep writes WEAK_NOT_TAKEN to every entry after reset.
// Once the sweep is done, the table serves registered one-cycle lookups and
// applies single-cycle read-modify-write updates from branch resolution.

// pred_fsm: next-state function of one 2-bit saturating counter.
module pred_fsm (
    input  logic [1:0] cur_state,
    input  logic       if_taken,
    output logic [1:0] next_state
);
    localparam logic [1:0] STRONG_NOT_TAKEN = 2'b00;
    localparam logic [1:0] STRONG_TAKEN     = 2'b11;

    // Step toward the outcome, saturating at both strong states.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        next_state = cur_state;
        if (if_taken) begin
            if (cur_state != STRONG_TAKEN) next_state = cur_state + 2'b01;
        end else begin
            if (cur_state != STRONG_NOT_TAKEN) next_state = cur_state - 2'b01;
        end
    end
endmodule

module pred_pht #(
    parameter int INDEX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lookup_en,
    input  logic        lookup_stall,
    input  logic [31:0] lookup_pc,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [1:0]  pred_state,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    output logic        init_busy
);
    localparam int         ENTRIES        = 1 << INDEX_W;
    localparam logic [1:0] WEAK_NOT_TAKEN = 2'b01;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [INDEX_W-1:0] init_idx_q, init_idx_d;
    logic [1:0]         pht_q [ENTRIES];
    logic               pred_valid_q, pred_valid_d;
    logic [1:0]         pred_state_q, pred_state_d;

    logic [INDEX_W-1:0] lookup_idx;
    logic [INDEX_W-1:0] upd_idx;
    logic [1:0]         upd_cur;
    logic [1:0]         upd_next;
    logic               upd_hits_lookup;

    logic               wr_en;
    logic [INDEX_W-1:0] wr_idx;
    logic [1:0]         wr_data;

    // Word-aligned PCs: bits [1:0] and everything above the index alias freely.
    assign lookup_idx = lookup_pc[INDEX_W+1:2];
    assign upd_idx    = upd_pc[INDEX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[31:INDEX_W+2], lookup_pc[1:0],
                              upd_pc[31:INDEX_W+2], upd_pc[1:0]};

    assign upd_cur         = pht_q[upd_idx];
    assign upd_hits_lookup = upd_en && (upd_idx == lookup_idx);

    pred_fsm u_pred_fsm (
        .cur_state  (upd_cur),
        .if_taken   (upd_taken),
        .next_state (upd_next)
    );

    // Sweep sequencing and selection of the single table write port.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        wr_en      = 1'b0;
        wr_idx     = upd_idx;
        wr_data    = upd_next;
        if (state_q == ST_INIT) begin
            wr_en      = 1'b1;
            wr_idx     = init_idx_q;
            wr_data    = WEAK_NOT_TAKEN;
            init_idx_d = init_idx_q + INDEX_W'(1);
            if (init_idx_q == {INDEX_W{1'b1}}) state_d = ST_RUN;
        end else begin
            // Updates arriving while the sweep runs are simply dropped.
            wr_en = upd_en;
        end
    end

    // Control state: reset restarts the sweep from entry 0, even mid-sweep.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    // Counter storage, written by the sweep or by a resolved update.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset of its own; the post-reset sweep initialises it.
        if (wr_en) pht_q[wr_idx] <= wr_data;
    end

    // Next prediction: hold while stalled, write-first forwarding on an index match.
    always_comb begin
        pred_valid_d = pred_valid_q;
        pred_state_d = pred_state_q;
        if (!lookup_stall) begin
            if ((state_q == ST_RUN) && lookup_en) begin
                pred_valid_d = 1'b1;
                pred_state_d = upd_hits_lookup ? upd_next : pht_q[lookup_idx];
            end else begin
                pred_valid_d = 1'b0;
                pred_state_d = 2'b00;
            end
        end
    end

    // Registered prediction outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid_q <= 1'b0;
            pred_state_q <= 2'b00;
        end else begin
            pred_valid_q <= pred_valid_d;
            pred_state_q <= pred_state_d;
        end
    end

    assign pred_valid = pred_valid_q;
    assign pred_state = pred_state_q;
    assign pred_taken = pred_state_q[1];
    assign init_busy  = (state_q == ST_INIT);
endmodule

// File: tb/tb_pred_pht.sv
// tb_pred_pht: scoreboard bench for pred_pht (INDEX_W = 6). Each cycle the
// bench predicts the registered outputs from its own table model, queues the
// prediction, and compares it after the next rising edge.
module tb_pred_pht;
    logic        clk = 1'b0;
    logic        rst;
    logic        lookup_en;
    logic        lookup_stall;
    logic [31:0] lookup_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [1:0]  pred_state;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        init_busy;

    pred_pht #(.INDEX_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_en    (lookup_en),
        .lookup_stall (lookup_stall),
        .lookup_pc    (lookup_pc),
        .pred_valid   (pred_valid),
        .pred_taken   (pred_taken),
        .pred_state   (pred_state),
        .upd_en       (upd_en),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .init_busy    (init_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] s;
        logic       b;
    } exp_t;

    exp_t exp_q[$];

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state.
    logic [1:0] m_tbl [64];
    logic       m_run = 1'b0;
    int         m_cnt = 0;
    logic       m_v   = 1'b0;
    logic [1:0] m_s   = 2'b00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] sat(input logic [1:0] cur, input logic t);
        if (t) return (cur == 2'b11) ? 2'b11 : cur + 2'b01;
        return (cur == 2'b00) ? 2'b00 : cur - 2'b01;
    endfunction

    // Drive one cycle, queue the model's expectation, compare after the edge.
    task automatic step(input logic r, input logic le, input logic [31:0] lpc,
                        input logic ue, input logic [31:0] upc, input logic ut,
                        input logic st);
        exp_t       e;
        exp_t       got;
        logic [5:0] li;
        logic [5:0] ui;
        @(negedge clk);
        rst = r; lookup_en = le; lookup_pc = lpc;
        upd_en = ue; upd_pc = upc; upd_taken = ut; lookup_stall = st;
        li = lpc[7:2];
        ui = upc[7:2];
        e.v = m_v;
        e.s = m_s;
        if (r) begin
            e.v = 1'b0;
            e.s = 2'b00;
        end else if (!st) begin
            if (m_run && le) begin
                e.v = 1'b1;
                e.s = (ue && ui == li) ? sat(m_tbl[ui], ut) : m_tbl[li];
            end else begin
                e.v = 1'b0;
                e.s = 2'b00;
            end
        end
        if (r) begin
            m_run = 1'b0;
            m_cnt = 0;
        end else if (m_run) begin
            if (ue) m_tbl[ui] = sat(m_tbl[ui], ut);
        end else begin
            m_tbl[m_cnt] = 2'b01;
            if (m_cnt == 63) m_run = 1'b1;
            m_cnt++;
        end
        m_v = e.v;
        m_s = e.s;
        e.b = !m_run;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check("pred_valid", 32'(pred_valid), 32'(got.v));
        check("pred_state", 32'(pred_state), 32'(got.s));
        check("pred_taken", 32'(pred_taken), 32'(got.s[1]));
        check("init_busy",  32'(init_busy),  32'(got.b));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // Count idle cycles until init_busy drops, bounded.
    task automatic wait_init(output int n);
        n = 0;
        while (init_busy && n < 200) begin
            idle();
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; lookup_en = 1'b0; lookup_stall = 1'b0; lookup_pc = '0;
        upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        for (int i = 0; i < 64; i++) m_tbl[i] = 2'b00;

        // Reset values, then the full sweep length.
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("rst_busy", 32'(init_busy), 32'd1);
        wait_init(n);
        check("init_len", n, 64);

        // Every index reads WEAK_NOT_TAKEN after the sweep.
        for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 32'(i) << 2, 1'b0, 32'h0, 1'b0, 1'b0);
        check("sweep_last", 32'(pred_state), 32'h1);

        // Reset at sweep cycle 30 with an update dropped mid-sweep.
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            if (i == 10) step(1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0);
            else idle();
        end
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        wait_init(n);
        check("reinit_len", n, 64);
        step(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
        check("drop_upd", 32'(pred_state), 32'h1);

        // Saturation at pc 0x100.
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
        check("sat_hi", 32'(pred_state), 32'h3);
        check("sat_hi_taken", 32'(pred_taken), 32'h1);
        repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
        check("sat_lo", 32'(pred_state), 32'h0);
        check("sat_lo_taken", 32'(pred_taken), 32'h0);

        // Same-cycle forwarding, then a different-index update.
        step(1'b0, 1'b1, 32'h10, 1'b1, 32'h10, 1'b1, 1'b0);
        check("fwd", 32'(pred_state), 32'h2);
        step(1'b0, 1'b1, 32'h10, 1'b1, 32'h20, 1'b1, 1'b0);
        check("no_fwd", 32'(pred_state), 32'h2);

        // Stall hold while an update changes the same entry.
        step(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h20, 1'b1, 32'h10, 1'b0, 1'b1);
        check("stall_hold0", 32'(pred_state), 32'h2);
        repeat (2) begin
            step(1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 1'b1);
            check("stall_hold", 32'(pred_state), 32'h2);
        end
        step(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0);
        check("post_stall", 32'(pred_state), 32'h1);

        // Idle lookup clears outputs.
        idle();
        check("idle_valid", 32'(pred_valid), 32'h0);

        // Aliasing: 0x104 and 0x1104 share an entry.
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1, 32'h104, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h1104, 1'b0, 32'h0, 1'b0, 1'b0);
        check("alias", 32'(pred_state), 32'h3);
        check("alias_valid", 32'(pred_valid), 32'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/pred_pht.md
# pred_pht

Pattern history table of 2-bit saturating counters for the IFU branch predictor. The fetch stage reads it to obtain a taken/not-taken prediction, and branch resolution updates it. Each entry holds a `pred_def.v` state, and the next state is computed by an instance of `pred_fsm`. After reset, the table initialises itself with a sweep before it serves predictions.

## Interface
- `INDEX_W`, default 6: table index width; the table has 2^INDEX_W entries.
- `clk`  input  1  clock.
- `rst`  input  1  synchronous, active-high reset.
- `lookup_en`  input  1  fetch presents a lookup this cycle.
- `lookup_stall`  input  1  fetch stalled; holds the prediction outputs.
- `lookup_pc`  input  32  fetch PC; index = `lookup_pc[INDEX_W+1:2]`.
- `pred_valid`  output  1  the prediction outputs carry a lookup result.
- `pred_taken`  output  1  predicted direction, equal to `pred_state[1]`.
- `pred_state`  output  2  counter value read for the lookup.
- `upd_en`  input  1  a resolved branch update is presented.
- `upd_pc`  input  32  PC of the resolved branch; index = `upd_pc[INDEX_W+1:2]`.
- `upd_taken`  input  1  actual branch outcome.
- `init_busy`  output  1  the initialisation sweep is in progress.

## Operation
- State encoding, from `pred_def.v`:
  - STRONG_NOT_TAKEN = 2'b00
  - WEAK_NOT_TAKEN = 2'b01
  - WEAK_TAKEN = 2'b10
  - STRONG_TAKEN = 2'b11
- Storage: a flop array of 2^INDEX_W entries, 2 bits each. Entry contents are not reset directly; the INIT sweep fills them.
- Control FSM states:
  - INIT: a counter `init_idx` of width INDEX_W writes WEAK_NOT_TAKEN to entry `init_idx` each cycle, then increments.
    - When `init_idx` = 2^INDEX_W−1 is written, the FSM moves to RUN on the next edge.
    - `init_busy` = 1 throughout INIT.
  - RUN: normal lookup and update; `init_busy` = 0.
- `rst` forces INIT with `init_idx` = 0 from any state, including mid-sweep. The sweep restarts from entry 0.
- Updates in RUN:
  - The entry at the update index is read combinationally and passed as `cur_state` to `pred_fsm`, with `if_taken` = `upd_taken`.
  - `next_state` is written at the same edge.
  - Saturation is handled by `pred_fsm`: STRONG_TAKEN with taken stays STRONG_TAKEN, and STRONG_NOT_TAKEN with not-taken stays STRONG_NOT_TAKEN.
- Updates during INIT are dropped.
- Lookups in RUN with `lookup_en`=1 and `lookup_stall`=0:
  - The registered outputs load `pred_valid`=1 and `pred_state` = entry value.
  - If `upd_en` targets the same index in the same cycle, the lookup takes the forwarded `pred_fsm` `next_state` (write-first).
- `lookup_en`=0 with `lookup_stall`=0: `pred_valid` loads 0, and `pred_state` and `pred_taken` load 0.
- `lookup_stall`=1: all prediction outputs hold their values. Updates still proceed, and held outputs are not refreshed by them.
- Lookups during INIT:
  - Output `pred_valid`=0 and `pred_state`=0, unless stalled.
  - Fetch treats this as predict not-taken.

## Timing
- Reset values, on the cycle after `rst` is sampled high:
  - `init_busy`=1
  - `pred_valid`=0
  - `pred_taken`=0
  - `pred_state`=2'b00
- INIT length is exactly 2^INDEX_W cycles after `rst` deasserts. `init_busy` falls on the edge after the last entry is written (64 cycles for the default).
- Lookup latency is 1 cycle: PC presented at edge N, prediction valid after edge N+1.
- Update latency is 1 cycle: an update presented before edge N is visible to lookups presented in cycle N+1. In cycle N itself it is visible through the forward path.
- Back-to-back updates to the same index in consecutive cycles each see the previous result. Four taken updates from WEAK_NOT_TAKEN end at STRONG_TAKEN.
- Lookup and update to different indices in the same cycle are independent.
- Index wrap: PCs differing only above bit INDEX_W+1 alias to the same entry. This is intended.

## Test plan
- Reset, then idle:
  - `init_busy`=1 for 64 cycles, then 0.
  - Lookups on every index return `pred_state`=2'b01 and `pred_taken`=0, `pred_valid`=1.
- Assert `rst` at sweep cycle 30:
  - The sweep restarts, and `init_busy` stays high for 64 further cycles.
  - An update at `pc` 0x40 issued mid-sweep has no effect; the entry reads 2'b01 after INIT.
- Saturation at `pc` 0x100:
  - Three taken updates, then lookup → 2'b11, `pred_taken`=1.
  - Then five not-taken updates, then lookup → 2'b00, `pred_taken`=0.
- Same-cycle forwarding:
  - Entry 0x04 at 2'b01; `upd_en`/`upd_taken`=1 and `lookup_en` both at `pc` 0x10 → `pred_state`=2'b10 next cycle.
  - A different-index update leaves the lookup at the stored value.
- Stall hold:
  - Lookup yields 2'b10, then `lookup_stall`=1 for 3 cycles with a new `lookup_pc` and a not-taken update to the same entry.
  - Outputs stay 2'b10 during the stall; an unstalled lookup afterwards returns 2'b01.
- Aliasing: a taken update at `pc` 0x0000_0104 twice, then lookup at 0x0000_1104 (same low bits) → 2'b11.
